// File: rtl/uart_rx_mmio_pkg.sv
// Shared definitions for the UART receiver: FSM state type, register offsets
// and register bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam logic [3:0] OFF_RXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERRUN   = 2;
  localparam int unsigned STAT_FRAME_ERR = 3;

  localparam int unsigned CTRL_RX_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_mmio_sync_fifo.sv
// Synchronous FIFO; a simultaneous push and pop both succeed, even when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  // A pop frees the slot this edge, so a push into a full FIFO is still accepted.
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with receive FIFO, sticky error flags and a 16-byte
// memory-mapped register window on the core's load/store bus.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [31:0] bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [31:0] bus_wdata,
  output logic        bus_hit,
  output logic [31:0] bus_rdata,
  output logic        irq
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  logic            r_sync1, r_rx_s, r_rx_prev;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_overrun, r_frame_err, r_irq;
  logic [1:0]      r_ctrl;

  logic            w_start_edge, w_stop_done, w_push, w_ferr_set, w_pop;
  logic            w_wr_status, w_wr_ctrl;
  logic [3:0]      w_off;
  logic [7:0]      w_head;
  logic            w_full, w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic [31:0]     w_status;
  logic            w_unused;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_start_edge = ~r_rx_s & r_rx_prev;
  assign w_stop_done  = (r_state == ST_STOP) && (r_cnt == BIT_M1) && r_ctrl[CTRL_RX_EN];
  assign w_push       = w_stop_done & r_rx_s;
  assign w_ferr_set   = w_stop_done & ~r_rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (!r_ctrl[CTRL_RX_EN]) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == BIT_M1) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == BIT_M1) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_hit     = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off       = {bus_addr[3:2], 2'b00};
  assign w_pop       = bus_rd & bus_hit & (w_off == OFF_RXDATA);
  assign w_wr_status = bus_wr & bus_hit & (w_off == OFF_STATUS);
  assign w_wr_ctrl   = bus_wr & bus_hit & (w_off == OFF_CTRL);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Error set is evaluated first so it wins over a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_ctrl      <= 2'b01;
      r_irq       <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop)                   r_overrun <= 1'b1;
      else if (w_wr_status && bus_wdata[STAT_OVERRUN])  r_overrun <= 1'b0;
      if (w_ferr_set)                                   r_frame_err <= 1'b1;
      else if (w_wr_status && bus_wdata[STAT_FRAME_ERR]) r_frame_err <= 1'b0;
      if (w_wr_ctrl) r_ctrl <= bus_wdata[1:0];
      r_irq <= r_ctrl[CTRL_IRQ_EN] & (~w_empty | r_overrun | r_frame_err);
    end
  end

  always_comb begin
    w_status                 = '0;
    w_status[STAT_NOT_EMPTY] = ~w_empty;
    w_status[STAT_FULL]      = w_full;
    w_status[STAT_OVERRUN]   = r_overrun;
    w_status[STAT_FRAME_ERR] = r_frame_err;
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_hit) begin
      case (w_off)
        OFF_RXDATA: bus_rdata = w_empty ? '0 : {24'h0, w_head};
        OFF_STATUS: bus_rdata = w_status;
        OFF_CTRL:   bus_rdata = {30'h0, r_ctrl};
        default:    bus_rdata = '0;
      endcase
    end
  end

  assign irq      = r_irq;
  assign w_unused = &{1'b0, bus_wdata[31:4], bus_addr[1:0], w_count};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Randomised scoreboard bench for uart_rx_mmio against a queue-based model.
module tb_uart_rx_mmio;

  localparam int unsigned CPB  = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_RX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_CT = BASE + 32'h8;
  localparam logic [31:0] A_NC = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] bus_addr = '0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic        bus_hit;
  logic [31:0] bus_rdata;
  logic        irq;

  always #5 clk = ~clk;

  uart_rx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_hit   (bus_hit),
    .bus_rdata (bus_rdata),
    .irq       (irq)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: the receive buffer is a plain byte queue.
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;
  logic [1:0] m_ctrl = 2'b01;

  function automatic logic [31:0] m_status();
    return {28'h0, m_ferr, m_ovr, (mq.size() == 8), (mq.size() != 0)};
  endfunction

  function automatic logic m_irq();
    return m_ctrl[1] & ((mq.size() != 0) | m_ovr | m_ferr);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus_rd === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got read with no expectation, expected none at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.name, bus_rdata, mon_e.data);
        check({mon_e.name, "_hit"}, {31'h0, bus_hit}, {31'h0, mon_e.hit});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input string name);
    exp_t e;
    e.name = name;
    e.hit  = (addr[31:4] == BASE[31:4]);
    e.data = '0;
    if (e.hit) begin
      case (addr[3:2])
        2'd0: if (mq.size() != 0) e.data = {24'h0, mq.pop_front()};
        2'd1: e.data = m_status();
        2'd2: e.data = {30'h0, m_ctrl};
        default: e.data = '0;
      endcase
    end
    sb.push_back(e);
    bus_addr = addr;
    bus_rd   = 1'b1;
    step();
    bus_rd   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    if (addr[31:4] == BASE[31:4]) begin
      if (addr[3:2] == 2'd1) begin
        if (data[2]) m_ovr = 1'b0;
        if (data[3]) m_ferr = 1'b0;
      end else if (addr[3:2] == 2'd2) begin
        m_ctrl = data[1:0];
      end
    end
    bus_addr  = addr;
    bus_wdata = data;
    bus_wr    = 1'b1;
    step();
    bus_wr    = 1'b0;
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop);
    rx = 1'b1;
    if (m_ctrl[0]) begin
      if (!stop)               m_ferr = 1'b1;
      else if (mq.size() < 8)  mq.push_back(b);
      else                     m_ovr = 1'b1;
    end
  endtask

  task automatic check_irq(input string name);
    step();
    step();
    check(name, {31'h0, irq}, {31'h0, m_irq()});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] rb;
    #1;
    // Reset with rx toggling
    for (int i = 0; i < 3; i++) begin
      rx = ~rx;
      step();
    end
    rx = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check("irq_reset", {31'h0, irq}, 32'h0);
    rd(A_ST, "status_reset");
    rd(A_CT, "ctrl_reset");
    rd(A_RX, "rxdata_reset");
    rd(A_NC, "reserved_read");
    rd(32'h0000_2004, "miss_read");
    repeat (4) step();

    // Single byte with not_empty latency measurement
    bus_addr = A_ST;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int c = 0; c < 200 && lat < 0; c++) begin
          @(negedge clk);
          if (bus_rdata[0] === 1'b1) lat = c;
        end
      end
    join
    step();
    check("not_empty_latency", 32'(lat), 32'd155);
    rd(A_RX, "rx_single");
    rd(A_RX, "rx_single_empty");
    rd(A_ST, "status_single");

    // Glitch on rx
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    repeat (40) step();
    rd(A_ST, "status_glitch");

    // Framing error and W1C
    send_frame(8'h3C, 1'b0);
    repeat (4) step();
    rd(A_ST, "status_ferr");
    wr(A_ST, 32'h8);
    rd(A_ST, "status_ferr_clr");

    // Overrun with back-to-back frames
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    repeat (4) step();
    rd(A_ST, "status_overrun");
    for (int i = 0; i < 9; i++) rd(A_RX, "rx_overrun_drain");
    wr(A_ST, 32'h4);
    rd(A_ST, "status_ovr_clr");

    // Interrupt
    wr(A_CT, 32'h3);
    check_irq("irq_idle");
    send_frame(8'h5A, 1'b1);
    check_irq("irq_byte");
    rd(A_RX, "rx_irq");
    check_irq("irq_drained");

    // Pop coinciding with push into a full FIFO
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1);
    rd(A_ST, "status_prefull");
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        rd(A_RX, "rx_simul_pop");
      end
    join
    repeat (2) step();
    rd(A_ST, "status_simul");
    for (int i = 0; i < 8; i++) rd(A_RX, "rx_simul_drain");

    // rx_en cleared mid-frame
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (60) step();
        wr(A_CT, 32'h2);
      end
    join
    repeat (4) step();
    wr(A_CT, 32'h3);
    rd(A_ST, "status_rxen_off");

    // Randomised frames, gaps and reads
    for (int n = 0; n < 14; n++) begin
      rb = 8'($urandom);
      send_frame(rb, ($urandom_range(0, 5) != 0));
      repeat ($urandom_range(0, 12)) step();
      if ($urandom_range(0, 2) == 0) rd(A_ST, "status_rand");
      if ($urandom_range(0, 1) == 0) rd(A_RX, "rx_rand");
      if ($urandom_range(0, 3) == 0) wr(A_ST, 32'($urandom_range(0, 15)));
      check_irq("irq_rand");
    end
    for (int i = 0; i < 9; i++) rd(A_RX, "rx_final_drain");
    rd(A_ST, "status_final");

    repeat (4) step();
    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
